axil_addr_router: RTL and testbench

//  AXI4-Lite 1-to-NUM_SLV address router between the bus master and the peripheral slaves (SHA256, AES_CTR, PIC).

---
 rtl/axil_pkg.sv | 27 ++
 rtl/axil_req_latch.sv | 35 +++
 rtl/axil_addr_router.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_axil_addr_router.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the peripheral address router and its slaves.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int SLV_SHA = 0;
    localparam int SLV_AES = 1;
    localparam int SLV_PIC = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        ERR_B,
        ERR_R
    } router_state_e;

    typedef enum logic {
        LAST_RD,
        LAST_WR
    } rr_last_e;

endpackage

// File: rtl/axil_req_latch.sv
// Single-entry holding register for one AXI-Lite request channel (AW, W or AR).
module axil_req_latch #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         accept_en,
    input  logic         clr,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] data_q,
    output logic         full_q
);

    assign in_ready = accept_en && !full_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
        end else if (clr) begin
            full_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
        end
    end

    // Payload carries no reset; it is only observed while full_q is set.
    always_ff @(posedge clk_i) begin
        if (in_valid && in_ready) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/axil_addr_router.sv
// AXI4-Lite 1-to-NUM_SLV router: one transaction in flight, DECERR on unmapped regions,
// SLVERR when the selected slave stalls for TIMEOUT cycles.
module axil_addr_router
    import axil_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLV    = 3,
    parameter int REGION_LSB = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [ADDR_W-1:0]          s_awaddr,
    input  logic [2:0]                 s_awprot,
    input  logic                       s_awvalid,
    output logic                       s_awready,
    input  logic [DATA_W-1:0]          s_wdata,
    input  logic [DATA_W/8-1:0]        s_wstrb,
    input  logic                       s_wvalid,
    output logic                       s_wready,
    output logic [1:0]                 s_bresp,
    output logic                       s_bvalid,
    input  logic                       s_bready,
    input  logic [ADDR_W-1:0]          s_araddr,
    input  logic [2:0]                 s_arprot,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    output logic [DATA_W-1:0]          s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    output logic [NUM_SLV*ADDR_W-1:0]  m_awaddr,
    output logic [NUM_SLV*3-1:0]       m_awprot,
    output logic [NUM_SLV-1:0]         m_awvalid,
    input  logic [NUM_SLV-1:0]         m_awready,
    output logic [NUM_SLV*DATA_W-1:0]  m_wdata,
    output logic [NUM_SLV*DATA_W/8-1:0] m_wstrb,
    output logic [NUM_SLV-1:0]         m_wvalid,
    input  logic [NUM_SLV-1:0]         m_wready,
    input  logic [NUM_SLV*2-1:0]       m_bresp,
    input  logic [NUM_SLV-1:0]         m_bvalid,
    output logic [NUM_SLV-1:0]         m_bready,
    output logic [NUM_SLV*ADDR_W-1:0]  m_araddr,
    output logic [NUM_SLV*3-1:0]       m_arprot,
    output logic [NUM_SLV-1:0]         m_arvalid,
    input  logic [NUM_SLV-1:0]         m_arready,
    input  logic [NUM_SLV*DATA_W-1:0]  m_rdata,
    input  logic [NUM_SLV*2-1:0]       m_rresp,
    input  logic [NUM_SLV-1:0]         m_rvalid,
    output logic [NUM_SLV-1:0]         m_rready,
    output logic [1:0]                 sel_o,
    output logic                       busy_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int AX_W   = ADDR_W + 3;
    localparam int W_W    = DATA_W + STRB_W;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] LOW_MASK = {{(ADDR_W-REGION_LSB){1'b0}}, {REGION_LSB{1'b1}}};

    router_state_e state_q, state_d;
    rr_last_e      rr_q, rr_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    err_q, err_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            accept_en, wr_clr, rd_clr;
    logic            aw_full, w_full, ar_full;
    logic [AX_W-1:0] aw_q, ar_q;
    logic [W_W-1:0]  w_q;

    assign accept_en = rst_ni && (state_q == IDLE);

    axil_req_latch #(.W(AX_W)) u_aw_latch (
        .clk_i(clk_i), .rst_ni(rst_ni), .accept_en(accept_en), .clr(wr_clr),
        .in_data({s_awaddr, s_awprot}), .in_valid(s_awvalid), .in_ready(s_awready),
        .data_q(aw_q), .full_q(aw_full)
    );

    axil_req_latch #(.W(W_W)) u_w_latch (
        .clk_i(clk_i), .rst_ni(rst_ni), .accept_en(accept_en), .clr(wr_clr),
        .in_data({s_wdata, s_wstrb}), .in_valid(s_wvalid), .in_ready(s_wready),
        .data_q(w_q), .full_q(w_full)
    );

    axil_req_latch #(.W(AX_W)) u_ar_latch (
        .clk_i(clk_i), .rst_ni(rst_ni), .accept_en(accept_en), .clr(rd_clr),
        .in_data({s_araddr, s_arprot}), .in_valid(s_arvalid), .in_ready(s_arready),
        .data_q(ar_q), .full_q(ar_full)
    );

    // Grant looks through to beats being accepted this cycle so the slave sees valid one cycle later.
    logic              aw_hs, w_hs, ar_hs, wr_rdy, rd_rdy;
    logic [ADDR_W-1:0] aw_addr_eff, ar_addr_eff;
    logic [1:0]        wr_idx, rd_idx;

    assign aw_hs       = s_awvalid && s_awready;
    assign w_hs        = s_wvalid && s_wready;
    assign ar_hs       = s_arvalid && s_arready;
    assign wr_rdy      = (aw_full || aw_hs) && (w_full || w_hs);
    assign rd_rdy      = ar_full || ar_hs;
    assign aw_addr_eff = aw_full ? aw_q[AX_W-1:3] : s_awaddr;
    assign ar_addr_eff = ar_full ? ar_q[AX_W-1:3] : s_araddr;
    assign wr_idx      = aw_addr_eff[REGION_LSB +: 2];
    assign rd_idx      = ar_addr_eff[REGION_LSB +: 2];

    logic [NUM_SLV-1:0] sel_oh;
    logic               sl_awready, sl_wready, sl_bvalid, sl_arready, sl_rvalid;
    logic               aw_go, w_go, slv_act, active, tmo;

    assign sel_oh     = NUM_SLV'(1) << sel_q;
    assign sl_awready = m_awready[sel_q];
    assign sl_wready  = m_wready[sel_q];
    assign sl_bvalid  = m_bvalid[sel_q];
    assign sl_arready = m_arready[sel_q];
    assign sl_rvalid  = m_rvalid[sel_q];

    assign aw_go   = (state_q == WR_REQ) && !aw_done_q;
    assign w_go    = (state_q == WR_REQ) && !w_done_q;
    assign active  = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_REQ) || (state_q == RD_RESP);
    assign slv_act = (aw_go && sl_awready) || (w_go && sl_wready) ||
                     ((state_q == WR_RESP) && sl_bvalid) ||
                     ((state_q == RD_REQ) && sl_arready) ||
                     ((state_q == RD_RESP) && sl_rvalid);
    assign tmo     = (TIMEOUT != 0) && active && !slv_act && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        sel_d     = sel_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = active ? (slv_act ? '0 : cnt_q + 1'b1) : '0;
        wr_clr    = 1'b0;
        rd_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (wr_rdy && (!rd_rdy || rr_q == LAST_RD)) begin
                    rr_d  = LAST_WR;
                    sel_d = wr_idx;
                    if (int'(wr_idx) < NUM_SLV) begin
                        state_d = WR_REQ;
                    end else begin
                        state_d = ERR_B;
                        err_d   = RESP_DECERR;
                    end
                end else if (rd_rdy) begin
                    rr_d  = LAST_RD;
                    sel_d = rd_idx;
                    if (int'(rd_idx) < NUM_SLV) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = ERR_R;
                        err_d   = RESP_DECERR;
                    end
                end
            end
            WR_REQ: begin
                if (aw_go && sl_awready) aw_done_d = 1'b1;
                if (w_go && sl_wready)   w_done_d  = 1'b1;
                if (tmo) begin
                    state_d = ERR_B;
                    err_d   = RESP_SLVERR;
                end else if ((aw_done_q || sl_awready) && (w_done_q || sl_wready)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (sl_bvalid && s_bready) begin
                    state_d = IDLE;
                    wr_clr  = 1'b1;
                end else if (tmo) begin
                    state_d = ERR_B;
                    err_d   = RESP_SLVERR;
                end
            end
            RD_REQ: begin
                if (sl_arready) begin
                    state_d = RD_RESP;
                end else if (tmo) begin
                    state_d = ERR_R;
                    err_d   = RESP_SLVERR;
                end
            end
            RD_RESP: begin
                if (sl_rvalid && s_rready) begin
                    state_d = IDLE;
                    rd_clr  = 1'b1;
                end else if (tmo) begin
                    state_d = ERR_R;
                    err_d   = RESP_SLVERR;
                end
            end
            ERR_B: begin
                if (s_bready) begin
                    state_d = IDLE;
                    wr_clr  = 1'b1;
                end
            end
            ERR_R: begin
                if (s_rready) begin
                    state_d = IDLE;
                    rd_clr  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_q      <= LAST_RD;
            sel_q     <= '0;
            err_q     <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
        end
    end

    // Payload is broadcast; only the selected slice ever sees a valid or ready.
    assign m_awaddr  = {NUM_SLV{aw_q[AX_W-1:3] & LOW_MASK}};
    assign m_awprot  = {NUM_SLV{aw_q[2:0]}};
    assign m_wdata   = {NUM_SLV{w_q[W_W-1:STRB_W]}};
    assign m_wstrb   = {NUM_SLV{w_q[STRB_W-1:0]}};
    assign m_araddr  = {NUM_SLV{ar_q[AX_W-1:3] & LOW_MASK}};
    assign m_arprot  = {NUM_SLV{ar_q[2:0]}};
    assign m_awvalid = aw_go ? sel_oh : '0;
    assign m_wvalid  = w_go ? sel_oh : '0;
    assign m_bready  = ((state_q == WR_RESP) && s_bready) ? sel_oh : '0;
    assign m_arvalid = (state_q == RD_REQ) ? sel_oh : '0;
    assign m_rready  = ((state_q == RD_RESP) && s_rready) ? sel_oh : '0;

    always_comb begin
        s_bvalid = 1'b0;
        s_bresp  = RESP_OKAY;
        s_rvalid = 1'b0;
        s_rresp  = RESP_OKAY;
        s_rdata  = '0;
        unique case (state_q)
            WR_RESP: begin
                s_bvalid = sl_bvalid;
                s_bresp  = m_bresp[int'(sel_q)*2 +: 2];
            end
            RD_RESP: begin
                s_rvalid = sl_rvalid;
                s_rresp  = m_rresp[int'(sel_q)*2 +: 2];
                s_rdata  = m_rdata[int'(sel_q)*DATA_W +: DATA_W];
            end
            ERR_B: begin
                s_bvalid = 1'b1;
                s_bresp  = err_q;
            end
            ERR_R: begin
                s_rvalid = 1'b1;
                s_rresp  = err_q;
            end
            default: ;
        endcase
    end

    assign sel_o  = sel_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_axil_addr_router.sv
// Directed bench for axil_addr_router with three behavioural AXI-Lite slaves.
module tb_axil_addr_router;
    import axil_pkg::*;

    localparam int NS = 3;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0;
    logic [2:0]  s_awprot = '0, s_arprot = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, busy_o;
    logic [1:0]  s_bresp, s_rresp, sel_o;
    logic [31:0] s_rdata;

    logic [NS*32-1:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [NS*3-1:0]  m_awprot, m_arprot;
    logic [NS*4-1:0]  m_wstrb;
    logic [NS-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [NS-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [NS*2-1:0]  m_bresp, m_rresp;

    axil_addr_router #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NS), .REGION_LSB(16), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .sel_o(sel_o), .busy_o(busy_o)
    );

    // Behavioural slaves: always ready (PIC arready can be withheld), respond OKAY one cycle later.
    logic        pic_hang = 1'b0;
    logic [NS-1:0] bv, rv;
    logic [31:0] rd [NS];
    logic [31:0] awlog [NS];
    logic [31:0] wlog [NS];
    logic [3:0]  slog [NS];
    logic [31:0] arlog [NS];
    int aw_vcyc [NS];
    int w_vcyc [NS];
    int ar_vcyc [NS];
    int b_cnt = 0, cyc = 0, b_cyc = 0, r_cyc = 0;

    assign m_awready = '1;
    assign m_wready  = '1;
    assign m_arready = pic_hang ? 3'b011 : 3'b111;
    assign m_bresp   = '0;
    assign m_rresp   = '0;
    assign m_bvalid  = bv;
    assign m_rvalid  = rv;
    always_comb begin
        m_rdata = '0;
        for (int k = 0; k < NS; k++) m_rdata[k*32 +: 32] = rd[k];
    end

    always @(posedge clk) begin
        if (!rst_ni) begin
            bv <= '0;
            rv <= '0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (m_awvalid[k] && m_awready[k]) awlog[k] <= m_awaddr[k*32 +: 32];
                if (m_wvalid[k] && m_wready[k]) begin
                    wlog[k] <= m_wdata[k*32 +: 32];
                    slog[k] <= m_wstrb[k*4 +: 4];
                    bv[k]   <= 1'b1;
                end else if (bv[k] && m_bready[k]) begin
                    bv[k] <= 1'b0;
                end
                if (m_arvalid[k] && m_arready[k]) begin
                    arlog[k] <= m_araddr[k*32 +: 32];
                    rd[k]    <= 32'hC0DE_0000 | (k << 8) | {24'd0, m_araddr[k*32 +: 8]};
                    rv[k]    <= 1'b1;
                end else if (rv[k] && m_rready[k]) begin
                    rv[k] <= 1'b0;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < NS; k++) begin
            aw_vcyc[k] = 0; w_vcyc[k] = 0; ar_vcyc[k] = 0; rd[k] = '0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NS; k++) begin
            aw_vcyc[k] <= aw_vcyc[k] + int'(m_awvalid[k]);
            w_vcyc[k]  <= w_vcyc[k] + int'(m_wvalid[k]);
            ar_vcyc[k] <= ar_vcyc[k] + int'(m_arvalid[k]);
        end
        if (s_bvalid && s_bready) begin
            b_cnt <= b_cnt + 1;
            b_cyc <= cyc;
        end
        if (s_rvalid && s_rready) r_cyc <= cyc;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, output logic [1:0] resp);
        bit aw_d, w_d, a_f, w_f, got;
        int t;
        aw_d = 0; w_d = 0; got = 0; resp = 2'bxx;
        s_awaddr = addr; s_awprot = 3'd0; s_wdata = data; s_wstrb = strb;
        s_wvalid = 1'b1;
        for (t = 0; t < 200 && !(aw_d && w_d); t++) begin
            if (t >= w_lead && !aw_d) s_awvalid = 1'b1;
            @(negedge clk);
            a_f = s_awvalid && s_awready;
            w_f = s_wvalid && s_wready;
            @(posedge clk); #1;
            if (a_f) begin aw_d = 1; s_awvalid = 1'b0; end
            if (w_f) begin w_d = 1; s_wvalid = 1'b0; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!(aw_d && w_d)) chk("wr_req_bound", 32'd0, 32'd1);
        s_bready = 1'b1;
        for (t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (s_bvalid) begin got = 1; resp = s_bresp; end
            @(posedge clk); #1;
        end
        s_bready = 1'b0;
        if (!got) chk("wr_resp_bound", 32'd0, 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        bit f;
        int t;
        f = 0; data = 'x; resp = 2'bxx; lat = 0;
        s_araddr = addr; s_arprot = 3'd0; s_arvalid = 1'b1;
        for (t = 0; t < 200 && !f; t++) begin
            @(negedge clk);
            f = s_arready;
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        if (!f) chk("rd_req_bound", 32'd0, 32'd1);
        f = 0;
        s_rready = 1'b1;
        while (!f && lat < 200) begin
            @(negedge clk);
            if (s_rvalid) begin f = 1; data = s_rdata; resp = s_rresp; end
            else lat++;
            @(posedge clk); #1;
        end
        s_rready = 1'b0;
        if (!f) chk("rd_resp_bound", 32'd0, 32'd1);
    endtask

    logic [1:0]  resp, resp2;
    logic [31:0] rdat;
    int lat, base_b, base_aw, base_ar, t5;
    bit b_seen, r_seen;

    initial begin
        // Reset state, with master valids already asserted
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("idle_awready", 32'(s_awready), 32'd1);
        @(posedge clk); #1;

        // 1: write to SHA
        axi_write(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, resp);
        chk("t1_bresp", 32'(resp), 32'(RESP_OKAY));
        chk("t1_awaddr", awlog[SLV_SHA], 32'h4);
        chk("t1_wdata", wlog[SLV_SHA], 32'hDEAD_BEEF);
        chk("t1_wstrb", 32'(slog[SLV_SHA]), 32'hF);
        chk("t1_aw_cycles", 32'(aw_vcyc[SLV_SHA]), 32'd1);
        chk("t1_others_idle", 32'(aw_vcyc[SLV_AES] + aw_vcyc[SLV_PIC] + w_vcyc[SLV_AES] + w_vcyc[SLV_PIC]), 32'd0);
        chk("t1_busy", 32'(busy_o), 32'd0);

        // 2: write to AES with W leading AW by 3 cycles
        base_b = b_cnt;
        axi_write(32'h0001_0010, 32'h1234_5678, 4'h3, 3, resp);
        repeat (5) @(posedge clk); #1;
        chk("t2_bresp", 32'(resp), 32'(RESP_OKAY));
        chk("t2_awaddr", awlog[SLV_AES], 32'h10);
        chk("t2_wdata", wlog[SLV_AES], 32'h1234_5678);
        chk("t2_wstrb", 32'(slog[SLV_AES]), 32'h3);
        chk("t2_one_b", 32'(b_cnt - base_b), 32'd1);

        // 3: read from PIC
        axi_read(32'h0002_0000, rdat, resp, lat);
        chk("t3_araddr", arlog[SLV_PIC], 32'h0);
        chk("t3_rdata", rdat, 32'hC0DE_0200);
        chk("t3_rresp", 32'(resp), 32'(RESP_OKAY));
        chk("t3_latency", 32'(lat), 32'd1);

        // 4: unmapped region 3, read then write
        base_aw = aw_vcyc[0] + aw_vcyc[1] + aw_vcyc[2];
        base_ar = ar_vcyc[0] + ar_vcyc[1] + ar_vcyc[2];
        axi_read(32'h0003_0000, rdat, resp, lat);
        chk("t4_rresp", 32'(resp), 32'(RESP_DECERR));
        chk("t4_rdata", rdat, 32'd0);
        axi_write(32'h0003_0000, 32'hAAAA_5555, 4'hF, 0, resp);
        chk("t4_bresp", 32'(resp), 32'(RESP_DECERR));
        chk("t4_no_ar", 32'(ar_vcyc[0] + ar_vcyc[1] + ar_vcyc[2]), 32'(base_ar));
        chk("t4_no_aw", 32'(aw_vcyc[0] + aw_vcyc[1] + aw_vcyc[2]), 32'(base_aw));

        // 5: reset, then simultaneous write and read
        rst_ni = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_ni = 1'b1;
        s_awaddr = 32'h0000_0100; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_araddr = 32'h0001_0008;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        b_seen = 0; r_seen = 0; resp = 2'bxx; resp2 = 2'bxx; rdat = 'x;
        for (t5 = 0; t5 < 100 && !(b_seen && r_seen); t5++) begin
            @(negedge clk);
            if (s_bvalid && !b_seen) begin b_seen = 1; resp = s_bresp; end
            if (s_rvalid && !r_seen) begin r_seen = 1; resp2 = s_rresp; rdat = s_rdata; end
            @(posedge clk); #1;
        end
        s_bready = 1'b0; s_rready = 1'b0;
        chk("t5_both_done", 32'({b_seen, r_seen}), 32'd3);
        chk("t5_write_first", 32'(b_cyc < r_cyc), 32'd1);
        chk("t5_bresp", 32'(resp), 32'(RESP_OKAY));
        chk("t5_rresp", 32'(resp2), 32'(RESP_OKAY));
        chk("t5_rdata", rdat, 32'hC0DE_0108);
        chk("t5_sha_wdata", wlog[SLV_SHA], 32'h0BAD_F00D);

        // 6: PIC withholds arready -> SLVERR after 16 cycles, then AES write still works
        pic_hang = 1'b1;
        base_ar = ar_vcyc[SLV_PIC];
        axi_read(32'h0002_0004, rdat, resp, lat);
        chk("t6_rresp", 32'(resp), 32'(RESP_SLVERR));
        chk("t6_rdata", rdat, 32'd0);
        chk("t6_latency", 32'(lat), 32'd16);
        chk("t6_arvalid_cycles", 32'(ar_vcyc[SLV_PIC] - base_ar), 32'd16);
        pic_hang = 1'b0;
        axi_write(32'h0001_0020, 32'hFEED_0001, 4'hF, 0, resp);
        chk("t6_aes_bresp", 32'(resp), 32'(RESP_OKAY));
        chk("t6_aes_awaddr", awlog[SLV_AES], 32'h20);
        chk("t6_idle", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
